// File: rtl/pll_clock_monitor.sv
// PLL output clock qualifier: counts outclk_0 rising edges over a refclk-timed gate and
// holds sys_rst until enough consecutive windows land inside EXPECTED +/- TOL.
module pll_clock_monitor #(
  parameter int unsigned WINDOW       = 50000,
  parameter int unsigned EXPECTED     = 5000,
  parameter int unsigned TOL          = 50,
  parameter int unsigned GOOD_WINDOWS = 4
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        outclk_0,
  input  logic        locked,
  output logic        clk_ok,
  output logic        sys_rst,
  output logic [15:0] freq_count,
  output logic        meas_valid,
  output logic        fault,
  output logic [1:0]  state
);

  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned GW = $clog2(GOOD_WINDOWS + 1);
  localparam logic [16:0] LO = (EXPECTED >= TOL) ? 17'(EXPECTED - TOL) : '0;
  localparam logic [16:0] HI = 17'(EXPECTED + TOL);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    MEASURE   = 2'd1,
    GOOD      = 2'd2,
    FAULT     = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic          oc_s1, oc_s, oc_prev;
  logic          lk_s1, lk_s;
  logic          oc_rise;
  logic [WW-1:0] win_cnt;
  logic [15:0]   edge_cnt;
  logic [15:0]   edge_sum;
  logic [GW-1:0] good_cnt, good_nxt;
  logic          win_end;
  logic          in_range;
  logic          set_fault;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      oc_s1   <= 1'b0;
      oc_s    <= 1'b0;
      oc_prev <= 1'b0;
      lk_s1   <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      oc_s1   <= outclk_0;
      oc_s    <= oc_s1;
      oc_prev <= oc_s;
      lk_s1   <= locked;
      lk_s    <= lk_s1;
    end
  end

  assign oc_rise  = oc_s & ~oc_prev;
  assign edge_sum = (edge_cnt == 16'hFFFF) ? edge_cnt : edge_cnt + 16'(oc_rise);
  // A window result is discarded when lock is lost in the same cycle.
  assign win_end  = (cur != WAIT_LOCK) && lk_s && (win_cnt == WIN_LAST);
  assign in_range = ({1'b0, edge_sum} >= LO) && ({1'b0, edge_sum} <= HI);

  always_comb begin
    nxt       = cur;
    good_nxt  = good_cnt;
    set_fault = 1'b0;
    if ((cur != WAIT_LOCK) && !lk_s) begin
      nxt      = WAIT_LOCK;
      good_nxt = '0;
    end else begin
      case (cur)
        WAIT_LOCK: begin
          if (lk_s) begin
            nxt      = MEASURE;
            good_nxt = '0;
          end
        end
        MEASURE: begin
          if (win_end) begin
            if (in_range) begin
              good_nxt = good_cnt + GW'(1);
              if ((32'(good_cnt) + 32'd1) >= GOOD_WINDOWS) nxt = GOOD;
            end else begin
              good_nxt = '0;
            end
          end
        end
        GOOD: begin
          if (win_end && !in_range) begin
            nxt       = FAULT;
            set_fault = 1'b1;
          end
        end
        FAULT: begin
          nxt      = MEASURE;
          good_nxt = '0;
        end
        default: nxt = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cur      <= WAIT_LOCK;
      good_cnt <= '0;
    end else begin
      cur      <= nxt;
      good_cnt <= good_nxt;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      freq_count <= '0;
      meas_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      meas_valid <= win_end;
      if ((cur == WAIT_LOCK) || !lk_s) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (win_end) begin
        win_cnt    <= '0;
        edge_cnt   <= '0;
        freq_count <= edge_sum;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_sum;
      end
      if (set_fault) fault <= 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      clk_ok  <= 1'b0;
      sys_rst <= 1'b1;
    end else begin
      clk_ok  <= (cur == GOOD);
      sys_rst <= (cur != GOOD);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Randomized bench for pll_clock_monitor: a window-level reference model predicts every
// output each cycle, plus directed scenario checks on lock, fault and reset behaviour.
module tb_pll_clock_monitor;

  localparam int unsigned WINDOW       = 100;
  localparam int unsigned EXPECTED     = 10;
  localparam int unsigned TOL          = 1;
  localparam int unsigned GOOD_WINDOWS = 2;
  localparam int LO = (EXPECTED >= TOL) ? int'(EXPECTED - TOL) : 0;
  localparam int HI = int'(EXPECTED + TOL);

  localparam int S_WAIT  = 0;
  localparam int S_MEAS  = 1;
  localparam int S_GOOD  = 2;
  localparam int S_FAULT = 3;

  logic        refclk = 1'b0;
  logic        rst;
  logic        outclk_0;
  logic        locked;
  logic        clk_ok;
  logic        sys_rst;
  logic [15:0] freq_count;
  logic        meas_valid;
  logic        fault;
  logic [1:0]  state;

  pll_clock_monitor #(
    .WINDOW      (WINDOW),
    .EXPECTED    (EXPECTED),
    .TOL         (TOL),
    .GOOD_WINDOWS(GOOD_WINDOWS)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .outclk_0  (outclk_0),
    .locked    (locked),
    .clk_ok    (clk_ok),
    .sys_rst   (sys_rst),
    .freq_count(freq_count),
    .meas_valid(meas_valid),
    .fault     (fault),
    .state     (state)
  );

  always #5 refclk = ~refclk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: whole-window bookkeeping driven by the inputs as the design sees them
  // after its two-cycle synchronizer delay.
  typedef struct packed {
    int st;
    int win;
    int cnt;
    int good;
    int freq;
    bit mv;
    bit flt;
    bit ok;
    bit srst;
  } model_t;

  model_t   m;
  bit [2:0] oc_hist;
  bit [2:0] lk_hist;

  function automatic model_t model_init();
    model_t r;
    r      = '0;
    r.srst = 1'b1;
    return r;
  endfunction

  function automatic model_t model_next(input model_t p, input bit lk, input bit rise);
    model_t n;
    int     c;
    bit     ok_win;
    n      = p;
    n.mv   = 1'b0;
    n.ok   = (p.st == S_GOOD);
    n.srst = (p.st != S_GOOD);
    if (p.st == S_WAIT) begin
      n.win = 0;
      n.cnt = 0;
      if (lk) begin
        n.st   = S_MEAS;
        n.good = 0;
      end
    end else if (!lk) begin
      n.st   = S_WAIT;
      n.win  = 0;
      n.cnt  = 0;
      n.good = 0;
    end else begin
      c = p.cnt + int'(rise);
      if (c > 65535) c = 65535;
      if (p.win == int'(WINDOW) - 1) begin
        n.freq = c;
        n.mv   = 1'b1;
        n.win  = 0;
        n.cnt  = 0;
        ok_win = (c >= LO) && (c <= HI);
        if (p.st == S_MEAS) begin
          if (ok_win) begin
            n.good = p.good + 1;
            if (n.good >= int'(GOOD_WINDOWS)) n.st = S_GOOD;
          end else begin
            n.good = 0;
          end
        end else if (p.st == S_GOOD) begin
          if (!ok_win) begin
            n.st  = S_FAULT;
            n.flt = 1'b1;
          end
        end else begin
          n.st   = S_MEAS;
          n.good = 0;
        end
      end else begin
        n.win = p.win + 1;
        n.cnt = c;
        if (p.st == S_FAULT) begin
          n.st   = S_MEAS;
          n.good = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m       <= model_init();
      oc_hist <= '0;
      lk_hist <= '0;
    end else begin
      m       <= model_next(m, lk_hist[1], oc_hist[1] & ~oc_hist[2]);
      oc_hist <= {oc_hist[1:0], outclk_0};
      lk_hist <= {lk_hist[1:0], locked};
    end
  end

  int unsigned half = 5;
  int unsigned tog  = 0;
  bit          hold = 1'b0;
  int          cyc  = 0;
  int          last_mv = -1;
  bit          track_mv  = 1'b0;
  bit          saw_fault = 1'b0;
  bit          saw_ok    = 1'b0;

  task automatic compare_all();
    check("state", state, m.st);
    check("clk_ok", clk_ok, m.ok);
    check("sys_rst", sys_rst, m.srst);
    check("freq_count", freq_count, m.freq);
    check("meas_valid", meas_valid, m.mv);
    check("fault", fault, m.flt);
  endtask

  task automatic step();
    @(negedge refclk);
    cyc++;
    compare_all();
    if (state == 2'd3) saw_fault = 1'b1;
    if (clk_ok) saw_ok = 1'b1;
    if (track_mv && meas_valid) begin
      if (last_mv >= 0) check("mv_gap", cyc - last_mv, WINDOW);
      last_mv = cyc;
    end
  endtask

  task automatic drive_oc();
    if (!hold) begin
      tog++;
      if (tog >= half) begin
        outclk_0 = ~outclk_0;
        tog      = 0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      drive_oc();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_clk_ok", clk_ok, 0);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_freq", freq_count, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_fault", fault, 0);
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    locked   = 1'b0;
    outclk_0 = 1'b0;
    #2;

    // Nominal clock: 10 edges per window, GOOD after two windows.
    locked = 1'b1; half = 5; hold = 1'b0; tog = 0;
    reset_dut();
    track_mv = 1'b1; last_mv = -1;
    run(400);
    track_mv = 1'b0;
    check("s1_state", state, 2);
    check("s1_clk_ok", clk_ok, 1);
    check("s1_sys_rst", sys_rst, 0);
    check("s1_freq", freq_count, 10);

    // Too fast: 12 or 13 edges, never qualifies.
    half = 4; tog = 0;
    reset_dut();
    saw_ok = 1'b0;
    run(450);
    check("s2_state", state, 1);
    check("s2_clk_ok", clk_ok, 0);
    check("s2_freq_range", int'((freq_count >= 16'd12) && (freq_count <= 16'd13)), 1);
    check("s2_never_ok", saw_ok, 0);

    // Clock stops while GOOD.
    half = 5; tog = 0; hold = 1'b0;
    reset_dut();
    run(250 + int'($urandom_range(0, 99)));
    check("s3_good", state, 2);
    saw_fault = 1'b0;
    hold = 1'b1;
    run(320);
    check("s3_freq", freq_count, 0);
    check("s3_fault", fault, 1);
    check("s3_state", state, 1);
    check("s3_saw_fault", saw_fault, 1);

    // One-cycle lock drop while GOOD.
    hold = 1'b0; tog = 0;
    reset_dut();
    run(250 + int'($urandom_range(0, 99)));
    check("s4_good", state, 2);
    locked = 1'b0;
    run(1);
    locked = 1'b1;
    run(2);
    check("s4_wait", state, 0);
    check("s4_ok_lag", clk_ok, 1);
    run(1);
    check("s4_ok_drop", clk_ok, 0);
    track_mv = 1'b1; last_mv = -1;
    run(215);
    track_mv = 1'b0;
    check("s4_regood", state, 2);
    check("s4_ok", clk_ok, 1);

    // Reset mid-window while GOOD.
    reset_dut();
    run(250 + int'($urandom_range(0, 99)));
    check("s5_good", state, 2);
    reset_dut();
    run(50);
    check("s5_freq_hold0", freq_count, 0);
    run(200);
    check("s5_freq", freq_count, 10);

    // outclk stuck high.
    hold = 1'b1; outclk_0 = 1'b1;
    reset_dut();
    saw_ok = 1'b0;
    run(350);
    check("s6_freq", freq_count, 0);
    check("s6_state", state, 1);
    check("s6_never_ok", saw_ok, 0);

    // Random rates, stalls and lock glitches.
    hold = 1'b0; outclk_0 = 1'b0; tog = 0;
    reset_dut();
    for (int seg = 0; seg < 8; seg++) begin
      half = $urandom_range(3, 7);
      hold = ($urandom_range(0, 5) == 0);
      run(int'($urandom_range(60, 250)));
      if ($urandom_range(0, 2) == 0) begin
        locked = 1'b0;
        run(int'($urandom_range(1, 6)));
        locked = 1'b1;
      end
    end
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
